// File: rtl/latch_bank_ctrl.sv
// Write controller for a bank of quad transparent D latches: round-robin
// arbitration between two requesters, then setup -> gate pulse -> hold.
module latch_bank_ctrl #(
    parameter int NBANKS = 4,
    parameter int ABITS  = 2,
    parameter int GW     = 2
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req0,
    input  logic [ABITS-1:0]  addr0,
    input  logic [3:0]        data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ABITS-1:0]  addr1,
    input  logic [3:0]        data1,
    output logic              ack1,
    output logic              err,
    output logic [3:0]        d,
    output logic [NBANKS-1:0] g,
    output logic              busy
);

    localparam int CW = (GW > 1) ? $clog2(GW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_ERR
    } state_t;

    state_t            state, state_n;
    logic              last, last_n;
    logic              sel, sel_n;
    logic [ABITS-1:0]  cap_addr, cap_addr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [3:0]        d_n;
    logic [NBANKS-1:0] g_n;
    logic [NBANKS-1:0] onehot;
    logic              ack0_n, ack1_n, err_n, busy_n;
    logic              win;
    logic [ABITS-1:0]  w_addr;
    logic [3:0]        w_data;

    assign onehot = NBANKS'(1) << cap_addr;

    // On a tie the requester not granted last time wins; last resets to 1
    // so requester 0 takes the first tie.
    assign win    = (req0 && req1) ? !last : req1;
    assign w_addr = win ? addr1 : addr0;
    assign w_data = win ? data1 : data0;

    always_comb begin
        state_n    = state;
        last_n     = last;
        sel_n      = sel;
        cap_addr_n = cap_addr;
        cnt_n      = cnt;
        d_n        = d;
        g_n        = '0;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        err_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    sel_n      = win;
                    last_n     = win;
                    cap_addr_n = w_addr;
                    if (32'(w_addr) < NBANKS) begin
                        d_n     = w_data;
                        state_n = S_SETUP;
                    end else begin
                        ack0_n  = !win;
                        ack1_n  = win;
                        err_n   = 1'b1;
                        state_n = S_ERR;
                    end
                end
            end
            S_SETUP: begin
                cnt_n   = '0;
                g_n     = onehot;
                state_n = S_PULSE;
            end
            S_PULSE: begin
                if (cnt == CW'(GW - 1)) begin
                    ack0_n  = !sel;
                    ack1_n  = sel;
                    state_n = S_HOLD;
                end else begin
                    cnt_n = cnt + CW'(1);
                    g_n   = onehot;
                end
            end
            S_HOLD:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            sel      <= 1'b0;
            cap_addr <= '0;
            cnt      <= '0;
            d        <= '0;
            g        <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            sel      <= sel_n;
            cap_addr <= cap_addr_n;
            cnt      <= cnt_n;
            d        <= d_n;
            g        <= g_n;
            ack0     <= ack0_n;
            ack1     <= ack1_n;
            err      <= err_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
Write controller for a bank of quad transparent D latches (4 bits per bank, shared data bus, one gate enable per bank). It arbitrates round-robin between two requesters. Each write runs the sequence setup -> gate pulse -> hold, so data is stable before the gate opens and still stable after it closes. It sits between synchronous logic and the latch array, which holds the results as static outputs.

Parameters:
NBANKS, 4, number of latch banks (one g line each), 1..16
ABITS, 2, width of requester bank address
GW, 2, gate pulse width in clk cycles, >=1

Ports:
clk  input  1  system clock, rising edge
rst_  input  1  asynchronous reset, active low
req0  input  1  requester 0 write request, level
addr0  input  ABITS  requester 0 target bank
data0  input  4  requester 0 write data
ack0  output  1  requester 0 completion, one-cycle pulse
req1  input  1  requester 1 write request, level
addr1  input  ABITS  requester 1 target bank
data1  input  4  requester 1 write data
ack1  output  1  requester 1 completion, one-cycle pulse
err  output  1  high together with ackN when the address was out of range
d  output  4  shared latch data bus
g  output  NBANKS  per-bank gate enables, active high (high = transparent)
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. Any state change happens on the rising clk edge.
- Reset (rst_ low, asynchronous):
  - state=IDLE; d=0, g=0, ack0=ack1=0, err=0, busy=0.
  - Round-robin pointer set so requester 0 wins the first tie.
- Reset mid-operation:
  - g drops immediately and the transaction is discarded with no ack.
  - Whatever value the latch captured is left as is.
- States: IDLE, SETUP, PULSE, HOLD, ERR.
- IDLE:
  - At a clk edge with any req high: grant, capture addr and data of the winner, update the pointer.
  - If captured addr < NBANKS go to SETUP, else go to ERR.
  - No req: stay in IDLE, outputs unchanged. d keeps its last value.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last time wins. The pointer updates only on a grant.
- SETUP (1 cycle): d = captured data, g = 0.
- PULSE (GW cycles): g[addr]=1, all other g bits 0, d held. A cycle counter counts GW cycles.
- HOLD (1 cycle): g=0, d held, ack of the granted requester=1. Next state is IDLE.
- ERR (1 cycle): ack of the granted requester=1, err=1. g stays 0 and d is unchanged. Next state is IDLE.
- Latency: the grant edge starts SETUP. ack is high in cycle GW+2 after the grant edge; total occupancy is GW+2 cycles.
- Requester handshake:
  - Hold req, addr and data stable until ack is sampled high.
  - Deassert req at the same edge that samples ack, or issue a new request by keeping req high.
  - A req still high in the IDLE cycle after ack counts as a new request.
- The IDLE cycle after HOLD/ERR is mandatory, so back-to-back writes take GW+3 cycles each.
- Changes on req, addr or data during non-IDLE states are ignored, because the captured copies are used.
- Exactly one g bit at most is ever high. g is never high in the same cycle in which d changes.

Test Plan:
- Reset:
  - Stimulus: assert rst_=0 mid-PULSE (req0, addr0=1, data0=4'b1010).
  - Response: g=0, d=0, busy=0 immediately, no ack0. After release the unit is idle and accepts new requests.
- Single write:
  - Stimulus: GW=2, req0=1, addr0=2, data0=4'b1010.
  - Response, cycles after the grant edge:
    - cycle 1: d=1010, g=0000 (SETUP)
    - cycles 2-3: g=0100
    - cycle 4: g=0, ack0=1, err=0
    - then IDLE, busy=0.
- Tie and round robin:
  - Stimulus: req0 and req1 high together (addr0=0/data 0101, addr1=3/data 1100), both held until acked, then both raised again.
  - Response:
    - First sequence: requester 0 wins, g=0001, then requester 1 with g=1000.
    - Second round: requester 0 first again, because the pointer alternates.
- Out of range:
  - Stimulus: NBANKS=3, ABITS=2, req1=1, addr1=3, data1=1111.
  - Response: one ERR cycle with ack1=1 and err=1. g stays 000 throughout, d unchanged.
- Stability:
  - Stimulus: change data0 and addr0 to x during SETUP/PULSE of a write of 0011 to bank 1.
  - Response: d stays 0011 and g=0010 for GW cycles. d never changes while any g bit is high.
- Back-to-back:
  - Stimulus: req0 held high across its ack with new data 1001.
  - Response: one IDLE cycle follows, then a second SETUP with d=1001. Spacing between the two ack0 pulses is GW+3 cycles.
